// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, taken-branch flush, data-memory freeze with timeout error.
// Outputs are combinational from registered state plus inputs; counters update on the rising edge.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IfId_RS_One,
  input  logic [4:0]       IfId_RS_Two,
  input  logic             IdEx_MemRead,
  input  logic [4:0]       IdEx_rd,
  input  logic             Ex_Branch_Taken,
  input  logic             ExMem_MemRead,
  input  logic             ExMem_MemWrite,
  input  logic             Dmem_Ack,
  output logic             Dmem_Req,
  output logic             Pc_Write,
  output logic             Pc_Sel,
  output logic             IfId_Write,
  output logic             IfId_Flush,
  output logic             IdEx_Write,
  output logic             IdEx_Flush,
  output logic             ExMem_Write,
  output logic             MemWb_Bubble,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic mem_op, load_use, freeze;
  logic req_c, pc_write_c, pc_sel_c, ifid_write_c, ifid_flush_c;
  logic idex_write_c, idex_flush_c, exmem_write_c, bubble_c;

  assign mem_op   = ExMem_MemRead | ExMem_MemWrite;
  assign load_use = IdEx_MemRead && (IdEx_rd != 5'd0) &&
                    ((IdEx_rd == IfId_RS_One) || (IdEx_rd == IfId_RS_Two));

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    freeze        = 1'b0;
    req_c         = 1'b0;
    pc_write_c    = 1'b0;
    pc_sel_c      = 1'b0;
    ifid_write_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_write_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_write_c = 1'b0;
    bubble_c      = 1'b0;
    case (state_q)
      ST_ERROR: bubble_c = 1'b1;
      default: begin
        req_c  = mem_op;
        // In MEM_WAIT the EX/MEM stage is frozen, so only the ack decides.
        freeze = ((state_q == ST_MEM_WAIT) || mem_op) && !Dmem_Ack;
        if (freeze) begin
          bubble_c = 1'b1;
          if (state_q == ST_RUN) begin
            state_d = ST_MEM_WAIT;
            wait_d  = WAIT_W'(1);
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ST_ERROR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          state_d       = ST_RUN;
          wait_d        = '0;
          pc_write_c    = 1'b1;
          ifid_write_c  = 1'b1;
          idex_write_c  = 1'b1;
          exmem_write_c = 1'b1;
          // A taken branch flushes the younger instruction, masking any load-use on it.
          if (Ex_Branch_Taken) begin
            pc_sel_c     = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
          end else if (load_use) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_flush_c = 1'b1;
          end
        end
      end
    endcase
  end

  assign Dmem_Req     = reset_n & req_c;
  assign Pc_Write     = reset_n & pc_write_c;
  assign Pc_Sel       = reset_n & pc_sel_c;
  assign IfId_Write   = reset_n & ifid_write_c;
  assign IfId_Flush   = reset_n & ifid_flush_c;
  assign IdEx_Write   = reset_n & idex_write_c;
  assign IdEx_Flush   = reset_n & idex_flush_c;
  assign ExMem_Write  = reset_n & exmem_write_c;
  assign MemWb_Bubble = reset_n & bubble_c;
  assign Mem_Err      = reset_n & (state_q == ST_ERROR);
  assign Stall_Cnt    = stall_q;
  assign Flush_Cnt    = flush_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pc_write_c && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if (pc_sel_c && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: driver pushes model expectations, negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int T  = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [4:0]    rs1 = '0, rs2 = '0, idex_rd = '0;
  logic          idex_mr = 1'b0, br = 1'b0, exmr = 1'b0, exmw = 1'b0, ack = 1'b0;
  logic          Dmem_Req, Pc_Write, Pc_Sel, IfId_Write, IfId_Flush, IdEx_Write;
  logic          IdEx_Flush, ExMem_Write, MemWb_Bubble, Mem_Err;
  logic [CW-1:0] Stall_Cnt, Flush_Cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .IfId_RS_One(rs1), .IfId_RS_Two(rs2),
    .IdEx_MemRead(idex_mr), .IdEx_rd(idex_rd),
    .Ex_Branch_Taken(br), .ExMem_MemRead(exmr), .ExMem_MemWrite(exmw),
    .Dmem_Ack(ack), .Dmem_Req(Dmem_Req), .Pc_Write(Pc_Write), .Pc_Sel(Pc_Sel),
    .IfId_Write(IfId_Write), .IfId_Flush(IfId_Flush), .IdEx_Write(IdEx_Write),
    .IdEx_Flush(IdEx_Flush), .ExMem_Write(ExMem_Write), .MemWb_Bubble(MemWb_Bubble),
    .Mem_Err(Mem_Err), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  typedef struct {
    logic [9:0]    outs;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc_n  = 0;

  // Reference model: error flag, length of the current run of ack-less cycles, event tallies.
  bit            m_err   = 1'b0;
  int            m_wait  = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  task automatic cycle(input bit rst, input logic [4:0] a1, input logic [4:0] a2,
                       input bit mr, input logic [4:0] rd, input bit b,
                       input bit emr, input bit emw, input bit ak);
    exp_t e;
    bit req, pw, ps, iw, ifl, dw, dfl, ew, bub, err, mop, lu;
    @(posedge clk);
    #1;
    reset_n = rst; rs1 = a1; rs2 = a2; idex_mr = mr; idex_rd = rd;
    br = b; exmr = emr; exmw = emw; ack = ak;
    {req, pw, ps, iw, ifl, dw, dfl, ew, bub, err} = '0;
    mop = emr | emw;
    lu  = mr && rd != 0 && (rd == a1 || rd == a2);
    if (!rst) begin
      m_err = 0; m_wait = 0; m_stall = '0; m_flush = '0;
    end
    e.stall = m_stall;
    e.flush = m_flush;
    if (rst) begin
      if (m_err) begin
        bub = 1; err = 1;
        m_stall++;
      end else if (!ak && (m_wait > 0 || mop)) begin
        req = mop; bub = 1;
        m_stall++;
        m_wait++;
        if (m_wait > T) m_err = 1;
      end else begin
        req = mop; m_wait = 0;
        pw = 1; iw = 1; dw = 1; ew = 1;
        if (b) begin
          ps = 1; ifl = 1; dfl = 1;
          m_flush++;
        end else if (lu) begin
          pw = 0; iw = 0; dfl = 1;
          m_stall++;
        end
      end
    end
    e.outs = {req, pw, ps, iw, ifl, dw, dfl, ew, bub, err};
    e.cyc  = cyc_n;
    cyc_n++;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    cycle(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if ({Dmem_Req, Pc_Write, Pc_Sel, IfId_Write, IfId_Flush, IdEx_Write, IdEx_Flush,
           ExMem_Write, MemWb_Bubble, Mem_Err} !== mon_e.outs) begin
        fails++;
        $display("FAIL outs cyc %0d: got %b want %b (Req,PcW,PcSel,IfIdW,IfIdF,IdExW,IdExF,ExMemW,Bub,Err)",
                 mon_e.cyc, {Dmem_Req, Pc_Write, Pc_Sel, IfId_Write, IfId_Flush, IdEx_Write,
                 IdEx_Flush, ExMem_Write, MemWb_Bubble, Mem_Err}, mon_e.outs);
      end
      checks++;
      if (Stall_Cnt !== mon_e.stall) begin
        fails++;
        $display("FAIL stall_cnt cyc %0d: got %0d want %0d", mon_e.cyc, Stall_Cnt, mon_e.stall);
      end
      checks++;
      if (Flush_Cnt !== mon_e.flush) begin
        fails++;
        $display("FAIL flush_cnt cyc %0d: got %0d want %0d", mon_e.cyc, Flush_Cnt, mon_e.flush);
      end
    end
  end

  initial begin
    int k;
    cycle(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    cycle(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    idle();
    // load-use on rs2, then bubble clears it
    cycle(1, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, 0);
    cycle(1, 5'd1, 5'd5, 0, 5'd5, 0, 0, 0, 0);
    idle();
    // rd = x0 never stalls
    cycle(1, 5'd0, 5'd3, 1, 5'd0, 0, 0, 0, 0);
    idle();
    // branch masks a simultaneous load-use
    cycle(1, 5'd7, 5'd2, 1, 5'd7, 1, 0, 0, 0);
    idle();
    cycle(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    // three ack-less cycles then ack
    repeat (3) cycle(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    cycle(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
    idle();
    cycle(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    // timeout into ERROR, ack afterwards is ignored, reset recovers
    repeat (7) cycle(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    repeat (2) cycle(1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 1);
    cycle(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    idle();
    // reset dropped between edges while waiting
    repeat (2) cycle(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    cycle(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    idle();
    idle();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0));
    end
    @(posedge clk);
    k = 0;
    while (sb_q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    checks++;
    if (sb_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control for the 5-stage core. Sequences the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and flushes on taken branches.
- Freezes the pipeline while the data memory handshake is outstanding, with a timeout that latches an error.
- Keeps saturating stall and flush counters for debug.

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before entering ERROR (must be ≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- IfId_RS_One  in  5  rs1 field of the instruction in IF/ID
- IfId_RS_Two  in  5  rs2 field of the instruction in IF/ID
- IdEx_MemRead  in  1  MemRead of the instruction in ID/EX
- IdEx_rd  in  5  rd of the instruction in ID/EX
- Ex_Branch_Taken  in  1  branch resolved taken in EX
- ExMem_MemRead  in  1  MemRead in EX/MEM
- ExMem_MemWrite  in  1  MemWrite in EX/MEM
- Dmem_Ack  in  1  data memory completes the current access
- Dmem_Req  out  1  data memory request
- Pc_Write  out  1  PC load enable
- Pc_Sel  out  1  1 = load branch target (Pc_Imm)
- IfId_Write  out  1  IF/ID load enable
- IfId_Flush  out  1  clear IF/ID to NOP
- IdEx_Write  out  1  ID/EX load enable
- IdEx_Flush  out  1  load ID/EX with bubble (all control bits 0)
- ExMem_Write  out  1  EX/MEM load enable
- MemWb_Bubble  out  1  load MEM/WB with RegWrite=0
- Mem_Err  out  1  sticky timeout error
- Stall_Cnt  out  CNT_W  cycles with Pc_Write=0
- Flush_Cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State=RUN; wait counter, Stall_Cnt, Flush_Cnt and Mem_Err cleared to 0.
  - While reset_n=0, all enables, flushes, Pc_Sel and Dmem_Req are forced to 0.
  - Reset asserted mid-MEM_WAIT or in ERROR aborts immediately to RUN.
- Outputs are combinational from state plus inputs. State, wait counter and statistics counters are registered.
- Default (RUN, no event): all *_Write=1, all flushes=0, Pc_Sel=0, MemWb_Bubble=0.
- mem_op = ExMem_MemRead | ExMem_MemWrite. Dmem_Req = mem_op whenever state is RUN or MEM_WAIT.
- RUN with mem_op=1 and Dmem_Ack=1: access completes in the same cycle; no stall.
- RUN with mem_op=1 and Dmem_Ack=0:
  - Freeze all: Pc_Write, IfId_Write, IdEx_Write and ExMem_Write = 0; MemWb_Bubble=1.
  - Branch and load-use actions are suppressed.
  - Next state MEM_WAIT; wait counter set to 1.
- MEM_WAIT with Dmem_Ack=0:
  - Same freeze outputs; wait counter +1.
  - When the counter is at MEM_TIMEOUT, next state is ERROR.
- MEM_WAIT with Dmem_Ack=1: outputs as in RUN (pipeline advances, branch and load-use evaluated normally); next state RUN.
- ERROR:
  - All enables 0, MemWb_Bubble=1, Dmem_Req=0, Mem_Err=1.
  - Exit only via reset.
- Load-use: IdEx_MemRead=1, IdEx_rd≠0, and IdEx_rd equals IfId_RS_One or IfId_RS_Two.
  - Pc_Write=0, IfId_Write=0, IdEx_Flush=1 for one cycle.
  - Resolves by itself next cycle because the bubble clears IdEx_MemRead.
- Taken branch (Ex_Branch_Taken=1): Pc_Sel=1, Pc_Write=1, IfId_Flush=1, IdEx_Flush=1.
- Priority, highest first:
  1. Reset
  2. ERROR
  3. Memory freeze
  4. Taken branch (a load-use detected in the same cycle is ignored, since the younger instruction is flushed)
  5. Load-use
- Stall_Cnt: +1 on every cycle with Pc_Write=0 and reset_n=1, including ERROR; saturates at all-ones.
- Flush_Cnt: +1 on each cycle with Pc_Sel=1; saturates.
- An rd of x0 never causes a load-use stall.

Test Plan:
- Load-use: IdEx_MemRead=1, IdEx_rd=5, IfId_RS_Two=5 → one cycle of Pc_Write=0, IfId_Write=0, IdEx_Flush=1; next cycle (IdEx_MemRead=0) all enables=1; Stall_Cnt=1.
- x0 filter: IdEx_MemRead=1, IdEx_rd=0, IfId_RS_One=0 → no stall; Stall_Cnt stays 0.
- Branch over load-use: Ex_Branch_Taken=1 together with a load-use match → Pc_Sel=1, IfId_Flush=1, IdEx_Flush=1, Pc_Write=1; Flush_Cnt=1, Stall_Cnt=0.
- Memory wait: ExMem_MemRead=1, Dmem_Ack low for 3 cycles then high → Dmem_Req=1 for 4 cycles; 3 frozen cycles with MemWb_Bubble=1; state back in RUN; Stall_Cnt=3.
- Timeout: MEM_TIMEOUT=4, ExMem_MemWrite=1, Dmem_Ack never asserted → ERROR entered after 4 wait cycles; Mem_Err=1, Dmem_Req=0, enables stay 0; later Dmem_Ack=1 has no effect; reset_n pulse clears Mem_Err and both counters.
- Async reset mid-wait: drop reset_n between clock edges during MEM_WAIT → outputs go to 0 immediately without waiting for a clock edge; after release, RUN defaults apply.
